spi_arb_sched: RTL and testbench

SPI_ARB_SCHED -- requirements
Module: spi_arb_sched

---
 rtl/spi_arb_sched.sv | 173 +++++++++++++++++
 tb/tb_spi_arb_sched.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_arb_sched.sv
// spi_arb_sched: round-robin arbiter that schedules one SPI transaction at a
// time from four requesters onto a single SPI engine, with a forced idle gap
// between consecutive transactions.
// Optional feature macro: SPI_ARB_TIMEOUT_EN adds a WAIT_DONE watchdog that
// aborts a transaction after TIMEOUT_CYC cycles without spi_done.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | no transaction owned, waiting for any req
// ARB       | round-robin pick, latch requester word/size/index, assert gnt
// LAUNCH    | one-cycle spi_start with engine inputs already stable
// WAIT_DONE | waiting for spi_done (or watchdog expiry when enabled)
// COMPLETE  | one-cycle done pulse to the granted requester
// GAP       | GAP_CYC forced idle cycles before the next arbitration
module spi_arb_sched #(
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYC     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   req,
    input  logic [127:0] req_wdata,
    input  logic [7:0]   req_size,
    output logic [3:0]   gnt,
    output logic [3:0]   done,
    output logic         done_err,
    output logic [31:0]  rdata,
    output logic         spi_start,
    output logic [31:0]  spi_wdata,
    output logic [5:0]   spi_size,
    output logic [1:0]   spi_cs_sel,
    input  logic         spi_done,
    input  logic [31:0]  spi_rdata,
    output logic [15:0]  arb_status
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARB       = 3'd1,
        LAUNCH    = 3'd2,
        WAIT_DONE = 3'd3,
        COMPLETE  = 3'd4,
        GAP       = 3'd5
    } state_t;

    // GAP is entered with the counter preloaded so that it lasts GAP_CYC cycles.
    localparam logic [3:0] GAP_LOAD = (GAP_CYC == 0) ? 4'd0 : 4'(GAP_CYC - 1);

    state_t      state, state_nxt;
    logic [1:0]  last;
    logic [7:0]  count;
    logic [3:0]  gap_cnt;
    logic        pick_found;
    logic [1:0]  pick_idx;
    logic [1:0]  cand;
    logic [2:0]  pick_bytes;
    logic        timeout_hit;
    logic        to_flag;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [WD_W-1:0] wd_cnt;
    logic            err_r;
    assign timeout_hit = (wd_cnt == '0);
    assign done_err    = (state == COMPLETE) && err_r;
`else
    assign timeout_hit = 1'b0;
    assign to_flag     = 1'b0;
    assign done_err    = 1'b0;
`endif

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = last;
        cand       = last;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
        pick_bytes = {1'b0, req_size[{pick_idx, 1'b0} +: 2]} + 3'd1;
    end

    // Next-state decode and state-derived pulse outputs.
    always_comb begin
        state_nxt = state;
        spi_start = 1'b0;
        done      = 4'b0000;
        case (state)
            IDLE:      if (|req) state_nxt = ARB;
            ARB:       state_nxt = pick_found ? LAUNCH : IDLE;
            LAUNCH: begin
                spi_start = 1'b1;
                state_nxt = WAIT_DONE;
            end
            WAIT_DONE: if (spi_done || timeout_hit) state_nxt = COMPLETE;
            COMPLETE: begin
                done      = gnt;
                state_nxt = (GAP_CYC == 0) ? IDLE : GAP;
            end
            GAP:       if (gap_cnt == 4'd0) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // State register and the datapath registers updated per state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last       <= 2'd3;
            gnt        <= 4'b0000;
            rdata      <= 32'h0;
            spi_wdata  <= 32'h0;
            spi_size   <= 6'd8;
            spi_cs_sel <= 2'd0;
            count      <= 8'd0;
            gap_cnt    <= 4'd0;
        end else begin
            state <= state_nxt;
            case (state)
                ARB: if (pick_found) begin
                    last       <= pick_idx;
                    spi_cs_sel <= pick_idx;
                    gnt        <= 4'b0001 << pick_idx;
                    spi_wdata  <= req_wdata[{pick_idx, 5'b00000} +: 32];
                    spi_size   <= {pick_bytes, 3'b000};
                end
                WAIT_DONE: begin
                    if (spi_done) begin
                        rdata <= spi_rdata;
                        count <= count + 8'd1;
                    end else if (timeout_hit) begin
                        rdata <= 32'hDEAD_DEAD;
                        count <= count + 8'd1;
                    end
                end
                COMPLETE: begin
                    gnt     <= 4'b0000;
                    gap_cnt <= GAP_LOAD;
                end
                GAP: if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                default: ;
            endcase
        end
    end

`ifdef SPI_ARB_TIMEOUT_EN
    // Watchdog down-counter armed in LAUNCH; sticky flag survives until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt  <= '0;
            err_r   <= 1'b0;
            to_flag <= 1'b0;
        end else if (state == LAUNCH) begin
            wd_cnt <= WD_W'(TIMEOUT_CYC - 1);
            err_r  <= 1'b0;
        end else if (state == WAIT_DONE && !spi_done) begin
            if (timeout_hit) begin
                err_r   <= 1'b1;
                to_flag <= 1'b1;
            end else begin
                wd_cnt <= wd_cnt - 1'b1;
            end
        end
    end
`endif

    assign arb_status = {1'b0, to_flag, (state != IDLE), last, state, count};

endmodule

// File: tb/tb_spi_arb_sched.sv
// Directed testbench for spi_arb_sched (GAP_CYC=2, TIMEOUT_CYC=16).
module tb_spi_arb_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_wdata;
    logic [7:0]   req_size;
    logic [3:0]   gnt;
    logic [3:0]   done;
    logic         done_err;
    logic [31:0]  rdata;
    logic         spi_start;
    logic [31:0]  spi_wdata;
    logic [5:0]   spi_size;
    logic [1:0]   spi_cs_sel;
    logic         spi_done;
    logic [31:0]  spi_rdata;
    logic [15:0]  arb_status;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int prev_start = 0;
    int extra_done = 0;

    spi_arb_sched #(.TIMEOUT_CYC(16), .GAP_CYC(2)) dut (
        .clk(clk), .rst(rst), .req(req), .req_wdata(req_wdata), .req_size(req_size),
        .gnt(gnt), .done(done), .done_err(done_err), .rdata(rdata),
        .spi_start(spi_start), .spi_wdata(spi_wdata), .spi_size(spi_size),
        .spi_cs_sel(spi_cs_sel), .spi_done(spi_done), .spi_rdata(spi_rdata),
        .arb_status(arb_status)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        for (int i = 0; i < 60 && spi_start !== 1'b1; i++) tick();
        check("spi_start_seen", {31'b0, spi_start}, 32'd1);
        start_cyc = cyc;
    endtask

    task automatic do_txn(input logic [3:0] eg, input logic [31:0] ew, input logic [31:0] rd);
        wait_start();
        check("txn_gnt", {28'b0, gnt}, {28'b0, eg});
        check("txn_wdata", spi_wdata, ew);
        tick();
        spi_done  = 1'b1;
        spi_rdata = rd;
        tick();
        spi_done = 1'b0;
        check("txn_done", {28'b0, done}, {28'b0, eg});
        check("txn_rdata", rdata, rd);
    endtask

    initial begin
        rst = 1'b1; req = 4'b0; req_size = 8'b0; spi_done = 1'b0; spi_rdata = 32'h0;
        req_wdata = {32'h4444_0004, 32'h3333_0003, 32'h2222_0002, 32'hA5A5_1234};
        tick(); tick();
        rst = 1'b0;
        check("rst_status", {16'b0, arb_status}, 32'h0000_1800);
        check("rst_gnt", {28'b0, gnt}, 32'd0);
        check("rst_size", {26'b0, spi_size}, 32'd8);
        check("rst_rdata", rdata, 32'd0);
        check("rst_start", {31'b0, spi_start}, 32'd0);

        // Single request, size code 3, engine answers 10 cycles after start.
        req = 4'b0001; req_size = 8'b0000_0011;
        tick();
        check("s1_arb_state", {29'b0, arb_status[10:8]}, 32'd1);
        check("s1_no_start_yet", {31'b0, spi_start}, 32'd0);
        tick();
        check("s1_start", {31'b0, spi_start}, 32'd1);
        check("s1_size", {26'b0, spi_size}, 32'd32);
        check("s1_wdata", spi_wdata, 32'hA5A5_1234);
        check("s1_cs", {30'b0, spi_cs_sel}, 32'd0);
        check("s1_gnt", {28'b0, gnt}, 32'd1);
        tick();
        check("s1_start_pulse", {31'b0, spi_start}, 32'd0);
        for (int i = 0; i < 9; i++) tick();
        check("s1_still_wait", {29'b0, arb_status[10:8]}, 32'd3);
        spi_done = 1'b1; spi_rdata = 32'h0000_BEEF;
        tick();
        spi_done = 1'b0; req = 4'b0;
        check("s1_done", {28'b0, done}, 32'd1);
        check("s1_rdata", rdata, 32'h0000_BEEF);
        check("s1_count", {24'b0, arb_status[7:0]}, 32'd1);
        check("s1_done_err", {31'b0, done_err}, 32'd0);
        tick();
        check("s1_done_cleared", {28'b0, done}, 32'd0);
        check("s1_gnt_cleared", {28'b0, gnt}, 32'd0);
        spi_done = 1'b1; spi_rdata = 32'h1111_1111;
        tick();
        spi_done = 1'b0;
        tick();
        check("s1_idle", {29'b0, arb_status[10:8]}, 32'd0);
        check("s1_not_busy", {31'b0, arb_status[13]}, 32'd0);
        check("s1_stray_done_ignored", rdata, 32'h0000_BEEF);

        // Round-robin with all four requesting, launches exactly 7 cycles apart.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b1111; req_size = 8'b0;
        for (int i = 0; i < 5; i++) begin
            do_txn(4'b0001 << (i % 4), req_wdata[32*(i%4) +: 32], 32'hC000_0000 + i);
            if (i > 0) check("rr_spacing", start_cyc - prev_start, 32'd7);
            prev_start = start_cyc;
        end
        req = 4'b0;
        check("rr_count", {24'b0, arb_status[7:0]}, 32'd5);

        // Requester 1 withdraws mid-transaction; it still completes once.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0010;
        wait_start();
        check("wd_gnt", {28'b0, gnt}, 32'd2);
        check("wd_cs", {30'b0, spi_cs_sel}, 32'd1);
        tick();
        req = 4'b0;
        tick(); tick(); tick();
        check("wd_hold_gnt", {28'b0, gnt}, 32'd2);
        spi_done = 1'b1; spi_rdata = 32'h0BAD_F00D;
        tick();
        spi_done = 1'b0;
        check("wd_done", {28'b0, done}, 32'd2);
        extra_done = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (done != 4'b0) extra_done++;
        end
        check("wd_single_pulse", extra_done, 32'd0);
        check("wd_idle", {29'b0, arb_status[10:8]}, 32'd0);

        // Reset while in WAIT_DONE abandons the transaction.
        req = 4'b0100;
        wait_start();
        check("rm_gnt", {28'b0, gnt}, 32'd4);
        tick();
        check("rm_wait", {29'b0, arb_status[10:8]}, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rm_gnt_clear", {28'b0, gnt}, 32'd0);
        check("rm_state", {29'b0, arb_status[10:8]}, 32'd0);
        check("rm_no_done", {28'b0, done}, 32'd0);
        req = 4'b0101;
        do_txn(4'b0001, 32'hA5A5_1234, 32'h5555_AAAA);
        req = 4'b0;
        check("rm_count", {24'b0, arb_status[7:0]}, 32'd1);
        for (int i = 0; i < 4; i++) tick();

        // Engine never answers.
        req = 4'b1000;
        wait_start();
        check("to_gnt", {28'b0, gnt}, 32'd8);
        tick();
`ifdef SPI_ARB_TIMEOUT_EN
        for (int i = 0; i < 15; i++) tick();
        check("to_still_wait", {29'b0, arb_status[10:8]}, 32'd3);
        tick();
        req = 4'b0;
        check("to_done", {28'b0, done}, 32'd8);
        check("to_done_err", {31'b0, done_err}, 32'd1);
        check("to_rdata", rdata, 32'hDEAD_DEAD);
        check("to_flag", {31'b0, arb_status[14]}, 32'd1);
        check("to_count", {24'b0, arb_status[7:0]}, 32'd2);
`else
        for (int i = 0; i < 40; i++) tick();
        check("to_stuck_wait", {29'b0, arb_status[10:8]}, 32'd3);
        check("to_no_err", {31'b0, done_err}, 32'd0);
        check("to_no_flag", {31'b0, arb_status[14]}, 32'd0);
        spi_done = 1'b1; spi_rdata = 32'h7777_0000;
        tick();
        spi_done = 1'b0; req = 4'b0;
        check("to_late_done", {28'b0, done}, 32'd8);
`endif

        // 256 completions wrap the count back to zero.
        rst = 1'b1; tick(); rst = 1'b0;
        req = 4'b0001;
        for (int i = 0; i < 255; i++) do_txn(4'b0001, 32'hA5A5_1234, 32'(i));
        check("wrap_count_255", {24'b0, arb_status[7:0]}, 32'd255);
        do_txn(4'b0001, 32'hA5A5_1234, 32'h0000_0100);
        check("wrap_count_0", {24'b0, arb_status[7:0]}, 32'd0);
        req = 4'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
